// File: rtl/dmem_responder_pkg.sv
// Shared MMIO register map and TX_STATUS layout for the data-memory responder.
// Also holds the bitwise merge helper used by every masked write.
package dmem_responder_pkg;

    localparam logic [7:0] MMIO_TX_DATA   = 8'h00;
    localparam logic [7:0] MMIO_TX_STATUS = 8'h04;
    localparam logic [7:0] MMIO_CYCLE_LO  = 8'h08;
    localparam logic [7:0] MMIO_CYCLE_HI  = 8'h0C;
    localparam logic [7:0] MMIO_TOHOST    = 8'h10;

    localparam int TX_STAT_FULL    = 0;
    localparam int TX_STAT_EMPTY   = 1;
    localparam int TX_STAT_OVF     = 2;
    localparam int TX_STAT_CNT_LSB = 8;

    function automatic logic [31:0] masked_merge(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [31:0] mask);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Console TX FIFO: registered storage, head read straight from the slot at rd_ptr.
// A push into a full FIFO is accepted only if a pop frees a slot on the same edge.
module dmem_responder_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clr_overflow,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign count   = count_q;
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
            // a dropped byte wins over a same-cycle clear so no loss goes unreported
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with per-bit masked writes plus an MMIO window
// holding console TX, a free-running cycle counter and the tohost halt register.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_wr_en,
    input  logic [31:0] dmem_bit_wr_en,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wr_data,
    output logic [31:0] dmem_rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] exit_code
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic          mmio;
    logic [7:0]    offset;
    logic [63:0]   cycle_q;
    logic [31:0]   tx_status;
    logic          ram_we;
    logic          tx_push;
    logic          tx_clr_ovf;
    logic          tohost_we;
    logic          fifo_full;
    logic          fifo_ovf;
    logic [CW-1:0] fifo_count;
    logic          unused_addr_bits;

    assign mmio    = (dmem_addr[31:28] == MMIO_BASE[31:28]);
    assign ram_idx = dmem_addr[AW+1:2];
    assign offset  = {dmem_addr[7:2], 2'b00};

    // decode keeps only some address bits; the rest alias by design
    assign unused_addr_bits = ^dmem_addr;

    assign ram_we     = dmem_wr_en & ~mmio;
    assign tx_push    = dmem_wr_en & mmio & (offset == MMIO_TX_DATA) & (|dmem_bit_wr_en[7:0]);
    assign tx_clr_ovf = dmem_wr_en & mmio & (offset == MMIO_TX_STATUS);
    assign tohost_we  = dmem_wr_en & mmio & (offset == MMIO_TOHOST);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= masked_merge(mem[ram_idx], dmem_wr_data, dmem_bit_wr_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt      <= 1'b0;
            exit_code <= '0;
        end else if (tohost_we && !halt) begin
            halt      <= 1'b1;
            exit_code <= dmem_wr_data & dmem_bit_wr_en;
        end
    end

    dmem_responder_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (tx_push),
        .push_data    (dmem_wr_data[7:0]),
        .full         (fifo_full),
        .pop          (tx_ready),
        .head         (tx_data),
        .valid        (tx_valid),
        .count        (fifo_count),
        .clr_overflow (tx_clr_ovf),
        .overflow     (fifo_ovf)
    );

    always_comb begin
        tx_status                             = '0;
        tx_status[TX_STAT_FULL]               = fifo_full;
        tx_status[TX_STAT_EMPTY]              = ~tx_valid;
        tx_status[TX_STAT_OVF]                = fifo_ovf;
        tx_status[TX_STAT_CNT_LSB +: CW]      = fifo_count;
    end

    always_comb begin
        dmem_rd_data = '0;
        if (!mmio) begin
            dmem_rd_data = mem[ram_idx];
        end else begin
            case (offset)
                MMIO_TX_STATUS: dmem_rd_data = tx_status;
                MMIO_CYCLE_LO:  dmem_rd_data = cycle_q[31:0];
                MMIO_CYCLE_HI:  dmem_rd_data = cycle_q[63:32];
                MMIO_TOHOST:    dmem_rd_data = exit_code;
                default:        dmem_rd_data = '0;
            endcase
        end
    end

endmodule
